// File: rtl/wts_pkg.sv
// Shared types and defaults for the double-buffered weight register file.
// Holds the load FSM encoding and a lane extraction helper.
package wts_pkg;

  localparam int WTS_W_DEF = 17;
  localparam int LANES_DEF = 4;

  typedef enum logic {
    FILL,
    FULL
  } load_state_t;

  function automatic logic [WTS_W_DEF-1:0] lane_slice(
    input logic [WTS_W_DEF*LANES_DEF-1:0] word,
    input int unsigned                    idx
  );
    return word[idx*WTS_W_DEF +: WTS_W_DEF];
  endfunction

endpackage

// File: rtl/wts_bank.sv
// One weight bank: synchronous write, registered read.
// The read register only updates on re, so it holds between reads.
module wts_bank #(
  parameter  int WIDTH  = 68,
  parameter  int DEPTH  = 9,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             raddr_ok;

  assign raddr_ok = 32'(raddr) < DEPTH;

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (re) begin
      rdata <= raddr_ok ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/weights_bank_rf.sv
// Double-buffered weight register file: loader fills the shadow bank,
// compute reads the active bank, a swap handshake exchanges them.
module weights_bank_rf
  import wts_pkg::*;
#(
  parameter  int WTS_W  = WTS_W_DEF,
  parameter  int LANES  = LANES_DEF,
  parameter  int DEPTH  = 9,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WTS_W*LANES-1:0] load_data,
  input  logic                   swap_req,
  output logic                   swap_ack,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_valid,
  output logic [WTS_W*LANES-1:0] rd_data,
  output logic                   active_valid
);

  localparam int WORD_W = WTS_W * LANES;

  load_state_t       state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              act_sel;
  logic              wr_fire;
  logic              rd_sel;
  logic              rd_zero;
  logic              addr_ok;
  logic              we0;
  logic              we1;
  logic [WORD_W-1:0] q0;
  logic [WORD_W-1:0] q1;

  // Handshake outputs are combinational so that the ack cycle
  // is the same cycle whose closing edge performs the swap.
  assign load_ready = !reset && (state == FILL);
  assign swap_ack   = !reset && (state == FULL) && swap_req;
  assign wr_fire    = load_valid && load_ready;
  assign addr_ok    = 32'(rd_addr) < DEPTH;

  assign we0 = wr_fire && act_sel;
  assign we1 = wr_fire && !act_sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FILL;
      wr_ptr       <= '0;
      act_sel      <= 1'b0;
      active_valid <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (wr_fire) begin
            if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
              wr_ptr <= '0;
              state  <= FULL;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        FULL: begin
          if (swap_ack) begin
            act_sel      <= ~act_sel;
            active_valid <= 1'b1;
            state        <= FILL;
          end
        end
      endcase
    end
  end

  // Bank choice and zero-forcing are captured at the sampling edge,
  // so a read coincident with a swap still sees the old bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_sel   <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel  <= act_sel;
        rd_zero <= !active_valid || !addr_ok;
      end
    end
  end

  assign rd_data = rd_zero ? '0 : (rd_sel ? q1 : q0);

  wts_bank #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_bank0 (
    .clock (clock),
    .we    (we0),
    .waddr (wr_ptr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (q0)
  );

  wts_bank #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_bank1 (
    .clock (clock),
    .we    (we1),
    .waddr (wr_ptr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (q1)
  );

endmodule

// File: tb/tb_weights_bank_rf.sv
// Scoreboard bench for weights_bank_rf: directed scenarios then random
// traffic, compared against a bank-level reference model.
module tb_weights_bank_rf;
  import wts_pkg::*;

  localparam int W  = 17;
  localparam int L  = 4;
  localparam int D  = 9;
  localparam int AW = $clog2(D);
  localparam int DW = W * L;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_data = '0;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          active_valid;

  weights_bank_rf #(
    .WTS_W (W),
    .LANES (L),
    .DEPTH (D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .active_valid (active_valid)
  );

  always #5 clock = ~clock;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];

  // Reference: two banks, which one is active, how full the other is.
  logic [DW-1:0] mbank [2][D];
  int            mact   = 0;
  int            mcount = 0;
  bit            mav    = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [W-1:0] x;
    x = W'(v);
    return {L{x}};
  endfunction

  task automatic step();
    bit full;
    #1;
    full = (mcount == D);
    check("load_ready", DW'(load_ready), DW'(!reset && !full));
    check("swap_ack", DW'(swap_ack), DW'(!reset && full && swap_req));
    check("active_valid", DW'(active_valid), DW'(mav));
    if (reset) begin
      mact   = 0;
      mcount = 0;
      mav    = 1'b0;
    end else begin
      if (rd_en) begin
        if (!mav || int'(rd_addr) >= D) exp_q.push_back('0);
        else exp_q.push_back(mbank[mact][rd_addr]);
      end
      if (load_valid && !full) begin
        mbank[1-mact][mcount] = load_data;
        mcount++;
      end else if (full && swap_req) begin
        mact   = 1 - mact;
        mav    = 1'b1;
        mcount = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic cyc(input bit lv, input logic [DW-1:0] d, input bit sr,
                     input bit re, input int a);
    load_valid = lv;
    load_data  = d;
    swap_req   = sr;
    rd_en      = re;
    rd_addr    = AW'(a);
    step();
  endtask

  // Monitor: pops an expectation whenever the DUT presents read data.
  logic [DW-1:0] last = '0;
  logic [DW-1:0] e;
  bit            r;

  always @(posedge clock) begin
    r = reset;
    #2;
    if (r) begin
      check("reset_rd_valid", DW'(rd_valid), '0);
      check("reset_rd_data", rd_data, '0);
      last = '0;
    end else if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %h with no read pending", rd_data);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
        last = e;
      end
    end else begin
      check("rd_hold", rd_data, last);
    end
  end

  initial begin
    bit sreq;
    bit ack;
    @(negedge clock);
    repeat (2) cyc(0, '0, 0, 0, 0);
    reset = 1'b0;

    // Read before any bank is valid returns zero.
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0);

    // First fill with swap requested throughout.
    for (int i = 0; i < D; i++) cyc(1, rep(32'h1000 + i), 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    for (int i = 0; i < D; i++) cyc(0, '0, 0, 1, i);
    cyc(0, '0, 0, 0, 0);

    // Second fill; swap_req raised after 4 entries; read across swap.
    for (int i = 0; i < D; i++) cyc(1, rep(32'h2000 + i), i >= 4, 0, 0);
    cyc(0, '0, 1, 1, 4);
    cyc(0, '0, 0, 1, 4);
    cyc(0, '0, 0, 0, 0);

    // Extra loads while full are dropped; out-of-range reads give zero.
    for (int i = 0; i < D; i++) cyc(1, rep(32'h4000 + i), 0, 0, 0);
    cyc(1, rep(32'h7777), 0, 0, 0);
    cyc(1, rep(32'h7777), 0, 1, 9);
    cyc(0, '0, 0, 1, 15);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 8);
    cyc(0, '0, 0, 0, 0);

    // Reset in the middle of a fill, then a fresh fill and swap.
    for (int i = 0; i < 4; i++) cyc(1, rep(32'h5000 + i), 0, 0, 0);
    reset = 1'b1;
    cyc(0, '0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < D; i++) cyc(1, rep(32'h3000 + i), 0, 0, 0);
    cyc(0, '0, 1, 1, 2);
    for (int i = 0; i < D; i++) cyc(0, '0, 0, 1, i);

    // Random traffic; swap_req stays up until acknowledged.
    sreq = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!sreq) sreq = ($urandom_range(0, 3) == 0);
      ack = sreq && (mcount == D);
      cyc($urandom_range(0, 1) == 1,
          DW'({$urandom(), $urandom(), $urandom()}),
          sreq, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
      if (ack) sreq = 1'b0;
    end

    repeat (3) cyc(0, '0, 0, 0, 0);
    check("queue_drained", DW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
